// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the single write port of the register file.
// Two write-back requesters (A = ALU pipe, B = mul/div/load) share the port
// through valid/ready handshakes with round-robin priority. A software clear
// sequencer zeroes r1..r(NREG-1), one register per cycle.
// Optional feature macro: RF_WB_BYPASS_EN adds same-cycle write-to-read
// forwarding ports (rna/rnb, qa_in/qb_in -> qa/qb).
module rf_wb_arbiter #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_wn,
  input  logic [DW-1:0] a_d,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_wn,
  input  logic [DW-1:0] b_d,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          rf_we,
  output logic [AW-1:0] rf_wn,
  output logic [DW-1:0] rf_d
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  input  logic [DW-1:0] qa_in,
  input  logic [DW-1:0] qb_in,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb
`endif
);

  typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

  // The clear counter runs one step past NREG-1 so the final clear write can
  // still be on the rf_* outputs while the FSM is in CLEAR (busy covers it).
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_DONE = (AW+1)'(NREG);

  state_t        state, state_nxt;
  logic          prio_b;     // 0: A has priority on contention, 1: B
  logic [AW:0]   clr_cnt;

  logic          vld_p1;
  logic [AW-1:0] wn_p1;
  logic [DW-1:0] d_p1;

  // State register
  always_ff @(posedge clk) begin
    if (clrn) state <= ST_ARB;
    else      state <= state_nxt;
  end

  // Next-state: clear request leaves ARB, counter exhaustion leaves CLEAR
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:   if (clr_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == CNT_DONE) state_nxt = ST_ARB;
      default:  state_nxt = ST_ARB;
    endcase
  end

  // Outputs: combinational readies (one at most, never during reset/clear)
  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    clr_busy = (state == ST_CLEAR);
    if (!clrn && state == ST_ARB && !clr_req) begin
      if (a_valid && (!b_valid || !prio_b)) a_ready = 1'b1;
      else if (b_valid)                     b_ready = 1'b1;
    end
  end

  // ---- stage p0 -> p1: accepted write or clear write registered onto rf_* ----
  always_ff @(posedge clk) begin
    if (clrn) begin
      vld_p1  <= 1'b0;
      wn_p1   <= '0;
      d_p1    <= '0;
      clr_cnt <= CNT_ONE;
      prio_b  <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (clr_cnt != CNT_DONE) begin
        vld_p1  <= 1'b1;
        wn_p1   <= clr_cnt[AW-1:0];
        d_p1    <= '0;
        clr_cnt <= clr_cnt + CNT_ONE;
      end else begin
        vld_p1  <= 1'b0;
        clr_cnt <= CNT_ONE;
      end
    end else if (a_ready) begin
      // A write to r0 is accepted but never reaches the file
      vld_p1 <= (a_wn != '0);
      wn_p1  <= a_wn;
      d_p1   <= a_d;
      prio_b <= 1'b1;
    end else if (b_ready) begin
      vld_p1 <= (b_wn != '0);
      wn_p1  <= b_wn;
      d_p1   <= b_d;
      prio_b <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign rf_we = vld_p1;
  assign rf_wn = wn_p1;
  assign rf_d  = d_p1;

`ifdef RF_WB_BYPASS_EN
  // Forward the value being written this cycle to a matching reader
  always_comb begin
    qa = qa_in;
    qb = qb_in;
    if (vld_p1 && rna != '0 && rna == wn_p1) qa = d_p1;
    if (vld_p1 && rnb != '0 && rnb == wn_p1) qb = d_p1;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed vector table, hand-written clear and
// reset-mid-clear sequences, then randomized traffic against a reference model.
module tb_rf_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          clrn;
  logic          a_valid, b_valid, clr_req;
  logic          a_ready, b_ready, clr_busy;
  logic [AW-1:0] a_wn, b_wn;
  logic [DW-1:0] a_d, b_d;
  logic          rf_we;
  logic [AW-1:0] rf_wn;
  logic [DW-1:0] rf_d;

  rf_wb_arbiter #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk(clk), .clrn(clrn),
    .a_valid(a_valid), .a_ready(a_ready), .a_wn(a_wn), .a_d(a_d),
    .b_valid(b_valid), .b_ready(b_ready), .b_wn(b_wn), .b_d(b_d),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: clear countdown, priority flag, expected rf_* outputs
  int            m_clear_left = 0;
  bit            m_prio = 0;      // 0 = A first, 1 = B first
  bit            e_we = 0;
  logic [AW-1:0] e_wn = '0;
  logic [DW-1:0] e_d = '0;
  bit            g_a, g_b;

  task automatic model_comb();
    g_a = 0;
    g_b = 0;
    if (!clrn && m_clear_left == 0 && !clr_req) begin
      if (a_valid && b_valid) begin
        if (m_prio == 0) g_a = 1; else g_b = 1;
      end else if (a_valid) g_a = 1;
      else if (b_valid) g_b = 1;
    end
  endtask

  task automatic model_seq();
    int k;
    if (clrn) begin
      m_clear_left = 0; m_prio = 0; e_we = 0; e_wn = '0; e_d = '0;
    end else if (m_clear_left > 0) begin
      k = NREG - m_clear_left + 1;   // busy cycle index 1..NREG
      if (k <= NREG - 1) begin
        e_we = 1; e_wn = AW'(k); e_d = '0;
      end else e_we = 0;
      m_clear_left--;
    end else if (clr_req) begin
      m_clear_left = NREG;
      e_we = 0;
    end else if (g_a) begin
      e_we = (a_wn != 0); e_wn = a_wn; e_d = a_d; m_prio = 1;
    end else if (g_b) begin
      e_we = (b_wn != 0); e_wn = b_wn; e_d = b_d; m_prio = 0;
    end else e_we = 0;
  endtask

  task automatic settle();
    #3;
    model_comb();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  typedef struct {
    bit rst; bit av; logic [AW-1:0] awn; logic [DW-1:0] ad;
    bit bv; logic [AW-1:0] bwn; logic [DW-1:0] bd; bit clr;
    bit ear; bit ebr; bit ewe; bit chkwd; logic [AW-1:0] ewn; logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 1, 5'd3, 32'hA3, 1, 5'd7, 32'hB7, 0,  0, 0, 0, 1, 5'd0, 32'h0};
    tbl[1]  = '{0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0,  1, 0, 0, 1, 5'd0, 32'h0};
    tbl[2]  = '{0, 0, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0,  0, 0, 1, 1, 5'd5, 32'hDEADBEEF};
    tbl[3]  = '{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,  0, 0, 0, 0, 5'd0, 32'h0};
    tbl[4]  = '{1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,  0, 0, 0, 0, 5'd0, 32'h0};
    tbl[5]  = '{0, 1, 5'd3, 32'hA3, 1, 5'd7, 32'hB7, 0,  1, 0, 0, 1, 5'd0, 32'h0};
    tbl[6]  = '{0, 1, 5'd3, 32'hA3, 1, 5'd7, 32'hB7, 0,  0, 1, 1, 1, 5'd3, 32'hA3};
    tbl[7]  = '{0, 1, 5'd3, 32'hA3, 1, 5'd7, 32'hB7, 0,  1, 0, 1, 1, 5'd7, 32'hB7};
    tbl[8]  = '{0, 1, 5'd3, 32'hA3, 1, 5'd7, 32'hB7, 0,  0, 1, 1, 1, 5'd3, 32'hA3};
    tbl[9]  = '{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,  0, 0, 1, 1, 5'd7, 32'hB7};
    tbl[10] = '{0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0,  0, 1, 0, 0, 5'd0, 32'h0};
    tbl[11] = '{0, 1, 5'd3, 32'hA3, 1, 5'd7, 32'hB7, 0,  1, 0, 0, 0, 5'd0, 32'h0};
    tbl[12] = '{0, 1, 5'd3, 32'hA3, 1, 5'd7, 32'hB7, 0,  0, 1, 1, 1, 5'd3, 32'hA3};
    tbl[13] = '{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,  0, 0, 1, 1, 5'd7, 32'hB7};
    tbl[14] = '{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,  0, 0, 0, 0, 5'd0, 32'h0};

    clrn = 1; a_valid = 0; b_valid = 0; clr_req = 0;
    a_wn = '0; b_wn = '0; a_d = '0; b_d = '0;
    edge_step();

    // Directed vectors: reset, single write, contention, r0 drop
    for (int i = 0; i < 15; i++) begin
      clrn = tbl[i].rst; a_valid = tbl[i].av; a_wn = tbl[i].awn; a_d = tbl[i].ad;
      b_valid = tbl[i].bv; b_wn = tbl[i].bwn; b_d = tbl[i].bd; clr_req = tbl[i].clr;
      settle();
      chk($sformatf("vec%0d a_ready", i), 32'(a_ready), 32'(tbl[i].ear));
      chk($sformatf("vec%0d b_ready", i), 32'(b_ready), 32'(tbl[i].ebr));
      chk($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(tbl[i].ewe));
      chk($sformatf("vec%0d clr_busy", i), 32'(clr_busy), 32'd0);
      if (tbl[i].chkwd) begin
        chk($sformatf("vec%0d rf_wn", i), 32'(rf_wn), 32'(tbl[i].ewn));
        chk($sformatf("vec%0d rf_d", i), rf_d, tbl[i].ed);
      end
      edge_step();
    end

    // Full clear with A waiting
    clr_req = 1; a_valid = 1; a_wn = 5'd9; a_d = 32'h99;
    settle();
    chk("clr_req a_ready", 32'(a_ready), 32'd0);
    edge_step();
    clr_req = 0;
    for (int j = 1; j <= 32; j++) begin
      settle();
      chk($sformatf("clr%0d busy", j), 32'(clr_busy), 32'd1);
      chk($sformatf("clr%0d a_ready", j), 32'(a_ready), 32'd0);
      chk($sformatf("clr%0d rf_we", j), 32'(rf_we), 32'(j >= 2));
      if (j >= 2) begin
        chk($sformatf("clr%0d rf_wn", j), 32'(rf_wn), 32'(j - 1));
        chk($sformatf("clr%0d rf_d", j), rf_d, 32'd0);
      end
      edge_step();
    end
    settle();
    chk("post clr busy", 32'(clr_busy), 32'd0);
    chk("post clr a_ready", 32'(a_ready), 32'd1);
    chk("post clr rf_we", 32'(rf_we), 32'd0);
    edge_step();
    a_valid = 0;
    settle();
    chk("post clr write wn", 32'(rf_wn), 32'd9);
    chk("post clr write we", 32'(rf_we), 32'd1);
    edge_step();

    // Reset in the middle of a clear
    clr_req = 1;
    settle();
    edge_step();
    clr_req = 0; a_valid = 1; a_wn = 5'd4; a_d = 32'h44;
    for (int j = 1; j <= 11; j++) begin
      settle();
      if (j == 11) begin
        chk("midclr rf_wn", 32'(rf_wn), 32'd10);
        clrn = 1;
      end
      edge_step();
    end
    clrn = 0;
    settle();
    chk("abort busy", 32'(clr_busy), 32'd0);
    chk("abort rf_we", 32'(rf_we), 32'd0);
    chk("abort a_ready", 32'(a_ready), 32'd1);
    edge_step();
    a_valid = 0; clr_req = 1;
    settle();
    chk("abort write wn", 32'(rf_wn), 32'd4);
    edge_step();
    clr_req = 0;
    settle();
    chk("restart lead busy", 32'(clr_busy), 32'd1);
    chk("restart lead we", 32'(rf_we), 32'd0);
    edge_step();
    settle();
    chk("restart rf_we", 32'(rf_we), 32'd1);
    chk("restart rf_wn", 32'(rf_wn), 32'd1);
    edge_step();

    // Randomized traffic against the model
    clrn = 1;
    settle();
    edge_step();
    clrn = 0;
    for (int c = 0; c < 3000; c++) begin
      settle();
      chk("rnd a_ready", 32'(a_ready), 32'(g_a));
      chk("rnd b_ready", 32'(b_ready), 32'(g_b));
      chk("rnd clr_busy", 32'(clr_busy), 32'(m_clear_left > 0));
      chk("rnd rf_we", 32'(rf_we), 32'(e_we));
      if (e_we) begin
        chk("rnd rf_wn", 32'(rf_wn), 32'(e_wn));
        chk("rnd rf_d", rf_d, e_d);
      end
      edge_step();
      if (!a_valid || g_a) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_wn = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
        a_d = $urandom;
      end
      if (!b_valid || g_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_wn = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
        b_d = $urandom;
      end
      clr_req = ($urandom_range(0, 79) == 0);
      clrn = ($urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file (r0 hardwired to zero, async read, write on posedge clk).
- Shares that port between two write-back requesters: A (ALU pipe) and B (multi-cycle mul/div or load unit), using valid/ready handshakes and round-robin priority.
- Provides a software-visible clear sequencer that zeroes r1..r(NREG-1), one register per cycle.
- Outputs drive the register file's we/wn/d pins directly.

Parameters:
- AW, 5, register address width
- DW, 32, data width
- NREG, 32, number of registers including r0

Ports:
- clk  in  1  system clock; all state updates on posedge
- clrn  in  1  synchronous reset, active-high (asserted = 1)
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  A's write accepted this cycle
- a_wn  in  AW  A destination register
- a_d  in  DW  A write data
- b_valid  in  1  requester B has a write pending
- b_ready  out  1  B's write accepted this cycle
- b_wn  in  AW  B destination register
- b_d  in  DW  B write data
- clr_req  in  1  single-cycle pulse requesting a full register clear
- clr_busy  out  1  clear sequence in progress
- rf_we  out  1  register file write enable
- rf_wn  out  AW  register file write address
- rf_d  out  DW  register file write data

Behaviour:
- Reset (clrn=1 at posedge) forces:
  - state=ARB, prio=A, clear counter=1
  - rf_we=0, rf_wn=0, rf_d=0, clr_busy=0
  - a_ready and b_ready are 0 while clrn=1.
- States: ARB, CLEAR.
- ARB, handshake and grant:
  - A transfer occurs on a posedge where x_valid && x_ready.
  - Ready outputs are combinational. At most one ready is high per cycle, and only toward a valid requester.
  - Grant rule: if exactly one requester is valid, it is granted. If both are valid, the one named by prio is granted.
  - After any grant, prio points to the other requester. prio is unchanged in cycles with no grant.
- ARB, write timing:
  - rf_we/rf_wn/rf_d are registered. A transfer in cycle N appears on the rf_* outputs in cycle N+1, so the register file is written at the end of N+1.
  - rf_we=0 in any cycle following a cycle without a transfer.
- ARB, writes to r0:
  - A transfer with wn==0 is still accepted (ready=1) and still counts as a grant for prio.
  - The following cycle has rf_we=0; rf_wn/rf_d are don't-care.
- ARB, valid/data rules:
  - Requesters must hold valid, wn and d stable until accepted.
  - The arbiter never drops an accepted write.
- ARB to CLEAR:
  - clr_req=1 in ARB means: no ready this cycle (clear wins over simultaneous valids), and the next state is CLEAR.
  - A write accepted in the previous cycle still completes on rf_* during the first CLEAR cycle. Clear writes start one cycle later.
- CLEAR:
  - clr_busy=1 throughout. Both readies are 0.
  - Each cycle emits rf_we=1, rf_wn=counter, rf_d=0. The counter runs 1 to NREG-1.
  - After the write of NREG-1, return to ARB with counter=1 and clr_busy=0.
  - Total clear occupancy is NREG-1 write cycles (31 at default) plus one lead-in cycle.
  - clr_req during CLEAR is ignored and does not restart the sequence.
  - prio is preserved across CLEAR.
- Reset mid-CLEAR aborts the sequence immediately; registers already zeroed stay zero.
- Widths: wn compared at full AW. No arithmetic on data paths.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined:
  - Adds inputs rna, rnb (AW), qa_in, qb_in (DW) and outputs qa, qb (DW).
  - qa = (rf_we && rna!=0 && rna==rf_wn) ? rf_d : qa_in. qb is formed the same way from rnb/qb_in.
  - The path is purely combinational, so a reader sees the value being written in the same cycle.
  - During CLEAR a match forwards 0.
- When undefined: these ports do not exist and no comparators are built.

Test Plan:
- Reset: hold clrn=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_we=0, rf_wn=0, rf_d=0, clr_busy=0.
- Single requester: a_valid=1, a_wn=5, a_d=0xDEADBEEF for one cycle -> a_ready=1 that cycle; next cycle rf_we=1, rf_wn=5, rf_d=0xDEADBEEF; then rf_we=0.
- Contention: both valid continuously, a_wn=3, b_wn=7 -> grants alternate A,B,A,B starting with A after reset; rf_wn sequence is 3,7,3,7 on consecutive cycles with no bubbles.
- r0 drop: b_valid=1, b_wn=0, b_d=0x1234 -> b_ready=1; next cycle rf_we=0; next contended grant goes to A.
- Clear: clr_req pulse while a_valid=1 -> a_ready=0; clr_busy=1 for the next 32 cycles with rf_wn stepping 1..31 and rf_d=0; a_ready=1 on the first cycle back in ARB.
- Reset mid-clear: assert clrn when rf_wn=10 -> next cycle state=ARB, rf_we=0, clr_busy=0; a later clr_req restarts from rf_wn=1.
